// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared constants and helpers for the result deskew slice
package mm_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  // Bit offset of lane 'lane' inside a packed row of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Cycles from lane 0 entering the array edge to the row being visible at the buffer head.
  function automatic int deskew_latency(input int lanes);
    return lanes;
  endfunction

endpackage

// File: rtl/lane_delay.sv
// rtl/lane_delay.sv - per-lane data+valid shift line with synchronous clear
module lane_delay #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 0
) (
  input  logic                  clk,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_clr;
    assign unused_clk_clr = clk ^ clr_i;
    assign data_o  = data_i;
    assign valid_o = valid_i;
  end else begin : g_line
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;

    always_comb begin
      data_d[0]  = data_i;
      valid_d[0] = valid_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (clr_i) begin
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        valid_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
        valid_q <= valid_d;
      end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];
  end

endmodule

// File: rtl/result_deskew.sv
// rtl/result_deskew.sv - re-aligns skewed lane results into rows and buffers them
module result_deskew
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = 4,
  parameter int OUT_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [LANES*DATA_WIDTH-1:0] lane_data_i,
  input  logic [LANES-1:0]            lane_valid_i,
  input  logic                        flush_i,
  output logic                        space_o,
  output logic [LANES*DATA_WIDTH-1:0] out_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        overflow_o,
  output logic                        skew_err_o
);

  localparam int ROW_W = LANES * DATA_WIDTH;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int SC_W  = $clog2(LANES + 1);
  localparam int INF_W = (LANES > 1) ? LANES - 1 : 1;

  if (LANES < 1 || OUT_DEPTH < LANES) begin : g_param_chk
    $error("result_deskew: need LANES >= 1 and OUT_DEPTH >= LANES");
  end

  logic             clr;
  logic [SC_W-1:0]  since_clr_q, since_clr_d;
  logic [LANES-1:0] lane_valid_g, dly_valid;
  logic [ROW_W-1:0] row_data;

  assign clr = reset | flush_i;

  // After a clear, lane k ignores its input for k cycles so tails of rows cut by the clear never reach the aligner.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign lane_valid_g[k] = lane_valid_i[k] && (k == 0 || int'(since_clr_q) > k);

    lane_delay #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (deskew_latency(LANES) - 1 - k)
    ) u_dly (
      .clk    (clk),
      .clr_i  (clr),
      .data_i (lane_data_i[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .valid_i(lane_valid_g[k]),
      .data_o (row_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .valid_o(dly_valid[k])
    );
  end

  logic [INF_W-1:0] launch_q, launch_d;
  logic [SC_W-1:0]  inflight;

  always_comb begin
    launch_d = '0;
    inflight = '0;
    if (LANES > 1) begin
      launch_d[0] = lane_valid_g[0];
      for (int i = 1; i < INF_W; i++) launch_d[i] = launch_q[i-1];
      for (int i = 0; i < INF_W; i++) inflight = inflight + SC_W'(launch_q[i]);
    end
    since_clr_d = (since_clr_q < SC_W'(LANES)) ? since_clr_q + SC_W'(1) : since_clr_q;
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [ROW_W-1:0] mem_q [OUT_DEPTH];
  logic [ROW_W-1:0] mem_d [OUT_DEPTH];
  logic             ovf_q, ovf_d, skew_q, skew_d;
  logic             full, pop, push, row_full, row_mix;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_q == CNT_W'(OUT_DEPTH));
  assign row_full = &dly_valid;
  assign row_mix  = (|dly_valid) && !row_full;
  assign pop      = out_valid_o && out_ready_i;
  assign push     = row_full && (!full || pop);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    skew_d  = skew_q;
    if (push) begin
      mem_d[wr_q] = row_data;
      wr_d        = ptr_inc(wr_q);
    end
    if (pop) rd_d = ptr_inc(rd_q);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    if (row_full && full && !pop) ovf_d  = 1'b1;
    if (row_mix)                  skew_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      launch_q    <= '0;
      since_clr_q <= SC_W'(1);
    end else begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      launch_q    <= launch_d;
      since_clr_q <= since_clr_d;
    end
    // Sticky flags survive a flush; only reset clears them.
    if (reset) begin
      ovf_q  <= 1'b0;
      skew_q <= 1'b0;
    end else if (!flush_i) begin
      ovf_q  <= ovf_d;
      skew_q <= skew_d;
    end
  end

  assign out_valid_o = (count_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_q] : '0;
  assign space_o     = (int'(count_q) + int'(inflight)) < OUT_DEPTH;
  assign overflow_o  = ovf_q;
  assign skew_err_o  = skew_q;

endmodule

// File: tb/tb_result_deskew.sv
// tb/tb_result_deskew.sv - randomized bench for result_deskew (depth 8 and depth 5 side by side)
module tb_result_deskew;

  localparam int L    = 4;
  localparam int W    = 16;
  localparam int RW   = L * W;
  localparam int MAXC = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush_i, out_ready_i;
  logic [RW-1:0] lane_data_i;
  logic [L-1:0]  lane_valid_i;
  logic [1:0]    space_w, out_valid_w, ovf_w, skw_w;
  logic [RW-1:0] out_data_w [2];

  result_deskew #(.DATA_WIDTH(W), .LANES(L), .OUT_DEPTH(8)) u_dut_a (
    .clk(clk), .reset(reset), .lane_data_i(lane_data_i), .lane_valid_i(lane_valid_i),
    .flush_i(flush_i), .space_o(space_w[0]), .out_data_o(out_data_w[0]),
    .out_valid_o(out_valid_w[0]), .out_ready_i(out_ready_i),
    .overflow_o(ovf_w[0]), .skew_err_o(skw_w[0]));

  result_deskew #(.DATA_WIDTH(W), .LANES(L), .OUT_DEPTH(5)) u_dut_b (
    .clk(clk), .reset(reset), .lane_data_i(lane_data_i), .lane_valid_i(lane_valid_i),
    .flush_i(flush_i), .space_o(space_w[1]), .out_data_o(out_data_w[1]),
    .out_valid_o(out_valid_w[1]), .out_ready_i(out_ready_i),
    .overflow_o(ovf_w[1]), .skew_err_o(skw_w[1]));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  bit            launch_t [MAXC];
  bit            killed_t [MAXC];
  logic [RW-1:0] row_t    [MAXC];
  logic [L-1:0]  miss_t   [MAXC];

  logic [RW-1:0] q_a [$];
  logic [RW-1:0] q_b [$];
  bit            m_ovf [2];
  bit            m_skw [2];

  task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int dep_of(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  function automatic int qsize(input int d);
    if (d == 0) return q_a.size();
    return q_b.size();
  endfunction

  function automatic logic [RW-1:0] qhead(input int d);
    if (d == 0) return q_a[0];
    return q_b[0];
  endfunction

  task automatic qpush(input int d, input logic [RW-1:0] v);
    if (d == 0) q_a.push_back(v);
    else        q_b.push_back(v);
  endtask

  task automatic qpop(input int d);
    if (d == 0) void'(q_a.pop_front());
    else        void'(q_b.pop_front());
  endtask

  task automatic qclear(input int d);
    if (d == 0) q_a.delete();
    else        q_b.delete();
  endtask

  // Rows whose lane 0 has entered but that have not yet been turned into a buffer entry.
  function automatic int inflight_at(input int t);
    int n = 0;
    for (int s = t - (L - 1); s < t; s++)
      if (s >= 0 && launch_t[s] && !killed_t[s]) n++;
    return n;
  endfunction

  function automatic bit model_space(input int d);
    return (dep_of(d) - qsize(d) - inflight_at(cyc)) >= 1;
  endfunction

  task automatic step(input bit launch, input logic [RW-1:0] row, input logic [L-1:0] miss,
                      input bit fl, input bit rs, input bit rdy);
    int            t, src;
    logic [RW-1:0] ld;
    logic [L-1:0]  lv;
    logic [RW-1:0] exp_d;
    bit            exp_v, pop, full_row, drop;
    string         nm;
    t = cyc;
    launch_t[t] = launch;
    row_t[t]    = row;
    miss_t[t]   = miss;
    killed_t[t] = 1'b0;
    for (int k = 0; k < L; k++) begin
      src = t - k;
      if (src >= 0 && launch_t[src] && !miss_t[src][k]) begin
        lv[k]          = 1'b1;
        ld[k*W +: W]   = row_t[src][k*W +: W];
      end else begin
        lv[k]          = 1'b0;
        ld[k*W +: W]   = W'($urandom);
      end
    end
    lane_data_i  = ld;
    lane_valid_i = lv;
    flush_i      = fl;
    reset        = rs;
    out_ready_i  = rdy;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      nm    = (d == 0) ? "a" : "b";
      exp_v = (qsize(d) != 0);
      exp_d = exp_v ? qhead(d) : '0;
      check_eq({nm, "_valid"}, out_valid_w[d], exp_v);
      check_eq({nm, "_data"},  out_data_w[d],  exp_d);
      check_eq({nm, "_space"}, space_w[d],     model_space(d));
      check_eq({nm, "_ovf"},   ovf_w[d],       m_ovf[d]);
      check_eq({nm, "_skew"},  skw_w[d],       m_skw[d]);
    end
    src = t - (L - 1);
    for (int d = 0; d < 2; d++) begin
      pop = (qsize(d) != 0) && rdy;
      if (rs) begin
        qclear(d);
        m_ovf[d] = 1'b0;
        m_skw[d] = 1'b0;
      end else if (fl) begin
        qclear(d);
      end else begin
        full_row = 1'b0;
        if (src >= 0 && launch_t[src] && !killed_t[src]) begin
          if (miss_t[src] != '0) m_skw[d] = 1'b1;
          else                   full_row = 1'b1;
        end
        drop = full_row && qsize(d) == dep_of(d) && !pop;
        if (drop) m_ovf[d] = 1'b1;
        if (pop) qpop(d);
        if (full_row && !drop) qpush(d, row_t[src]);
      end
    end
    if (rs || fl)
      for (int s = t - (L - 1); s <= t; s++)
        if (s >= 0) killed_t[s] = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [RW-1:0] rnd_row();
    return {$urandom, $urandom};
  endfunction

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, rdy);
  endtask

  task automatic launch_row(input logic [RW-1:0] row, input bit rdy);
    step(1'b1, row, '0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    logic [RW-1:0] single_row;
    single_row   = 64'h0044_0033_0022_0011;
    reset        = 1'b1;
    flush_i      = 1'b0;
    out_ready_i  = 1'b0;
    lane_valid_i = '0;
    lane_data_i  = '0;
    @(posedge clk);
    #1;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    check_eq("rst_valid", out_valid_w[0], 1'b0);
    check_eq("rst_data",  out_data_w[0],  '0);
    check_eq("rst_space", space_w[0],     1'b1);
    check_eq("rst_ovf",   ovf_w[0],       1'b0);
    check_eq("rst_skew",  skw_w[0],       1'b0);

    // single row: head valid exactly LANES cycles after lane 0
    launch_row(single_row, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      check_eq("single_valid", out_valid_w[0], (i == L));
      if (i == L) check_eq("single_data", out_data_w[0], single_row);
      idle(1, 1'b1);
    end

    // back-to-back stream with a ready consumer
    for (int i = 0; i < 20; i++) begin
      check_eq("stream_space", space_w[0], 1'b1);
      launch_row(rnd_row(), 1'b1);
    end
    idle(L + 4, 1'b1);

    // lane 2 missing for one row, followed by a clean row
    step(1'b1, rnd_row(), 4'b0100, 1'b0, 1'b0, 1'b1);
    launch_row(rnd_row(), 1'b1);
    idle(L + 4, 1'b1);
    check_eq("skew_flag", skw_w[0], 1'b1);
    check_eq("skew_ovf",  ovf_w[0], 1'b0);

    // stalled consumer, launches continue past space_o
    for (int i = 0; i < 11; i++) begin
      if (i == 7) check_eq("ovf_space_hi", space_w[0], 1'b1);
      if (i == 8) check_eq("ovf_space_lo", space_w[0], 1'b0);
      launch_row(rnd_row(), 1'b0);
    end
    idle(L + 2, 1'b0);
    check_eq("ovf_flag", ovf_w[0], 1'b1);
    idle(14, 1'b1);

    // flush with 3 rows buffered and 2 still in the pipe
    for (int i = 0; i < 5; i++) launch_row(rnd_row(), 1'b0);
    idle(1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    check_eq("flush_valid", out_valid_w[0], 1'b0);
    check_eq("flush_space", space_w[0],     1'b1);
    check_eq("flush_ovf",   ovf_w[0],       1'b1);
    check_eq("flush_skew",  skw_w[0],       1'b1);
    idle(L + 2, 1'b1);

    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    check_eq("rst2_valid", out_valid_w[0], 1'b0);
    check_eq("rst2_data",  out_data_w[0],  '0);
    check_eq("rst2_space", space_w[0],     1'b1);
    check_eq("rst2_ovf",   ovf_w[0],       1'b0);
    check_eq("rst2_skew",  skw_w[0],       1'b0);

    // flush while rows are partially delivered; their tails must not look skewed
    launch_row(rnd_row(), 1'b1);
    step(1'b1, rnd_row(), '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) launch_row(rnd_row(), 1'b1);
    idle(L + 4, 1'b1);
    check_eq("mid_skew_a", skw_w[0], 1'b0);
    check_eq("mid_skew_b", skw_w[1], 1'b0);

    // random traffic honouring space on both depths
    for (int i = 0; i < 120; i++) begin
      if (($urandom % 2) == 1 && model_space(0) && model_space(1))
        launch_row(rnd_row(), 1'($urandom % 2));
      else
        idle(1, 1'($urandom % 2));
    end
    idle(16, 1'b1);
    check_eq("rand_ovf_b",   ovf_w[1],       1'b0);
    check_eq("rand_empty_b", out_valid_w[1], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
